timer_ctrl: RTL



---
 rtl/timer_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/timer_ctrl.sv
// timer_ctrl: MM:SS BCD stopwatch/countdown controlled by gesture pulses.
// Registered digits and status feed the 7-segment display driver.
module timer_ctrl #(
    parameter int TICK_DIV = 100000000,
    parameter int FAST_DIV = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flag_short,
    input  logic       flag_long,
    input  logic       flag_double,
    input  logic       flag_triple,
    input  logic       flag_four,
    input  logic       btn_long,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       count_down,
    output logic       running,
    output logic       set_mode,
    output logic       set_field,
    output logic       alarm
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int FW = FAST_DIV > 1 ? $clog2(FAST_DIV) : 1;
    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);
    localparam logic [FW-1:0] FAST_MAX = FW'(FAST_DIV - 1);

    typedef enum logic [2:0] {STOP, RUN, PAUSE, SET, DONE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    min_q, min_d, sec_q, sec_d, sel, nsel;
    logic [PW-1:0] pre_q, pre_d;
    logic [FW-1:0] fast_q, fast_d;
    logic          cd_q, cd_d, field_q, field_d, running_q, set_mode_q, alarm_q;
    logic          f4, f3, f2, fl, fs, any_flag, tick, fwrap, zero;

    function automatic logic [7:0] inc60(input logic [7:0] v);
        return v[3:0] >= 4'd9 ? (v[7:4] >= 4'd5 ? 8'h00 : {v[7:4] + 4'd1, 4'd0})
                              : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] dec60(input logic [7:0] v);
        return v[3:0] == 4'd0 ? (v[7:4] == 4'd0 ? 8'h59 : {v[7:4] - 4'd1, 4'd9})
                              : {v[7:4], v[3:0] - 4'd1};
    endfunction

    // One winning gesture per cycle: four > triple > double > long > short
    assign f4       = flag_four;
    assign f3       = flag_triple & ~flag_four;
    assign f2       = flag_double & ~flag_four & ~flag_triple;
    assign fl       = flag_long & ~flag_four & ~flag_triple & ~flag_double;
    assign fs       = flag_short & ~flag_four & ~flag_triple & ~flag_double & ~flag_long;
    assign any_flag = flag_four | flag_triple | flag_double | flag_long | flag_short;
    assign zero     = {min_q, sec_q} == 16'h0000;
    assign tick     = state_q == RUN && pre_q == TICK_MAX;
    assign fwrap    = state_q == SET && btn_long && fast_q == FAST_MAX;
    assign sel      = field_q ? min_q : sec_q;
    assign nsel     = f3 ? dec60(sel) : inc60(sel);

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        cd_d    = cd_q;
        field_d = field_q;
        pre_d   = '0;
        fast_d  = '0;
        case (state_q)
            STOP: begin
                if (f4) begin
                    state_d = SET;
                    field_d = 1'b0;
                end else if (f3) begin
                    cd_d  = ~cd_q;
                    min_d = 8'h00;
                    sec_d = 8'h00;
                end else if (f2 || fl) begin
                    min_d = 8'h00;
                    sec_d = 8'h00;
                end else if (fs && !(cd_q && zero)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                pre_d = tick ? '0 : pre_q + 1'b1;
                if (fs) state_d = PAUSE;
                if (tick && cd_q) begin
                    sec_d = dec60(sec_q);
                    min_d = sec_q == 8'h00 ? dec60(min_q) : min_q;
                    if (min_d == 8'h00 && sec_d == 8'h00) state_d = DONE;
                end else if (tick) begin
                    sec_d = inc60(sec_q);
                    min_d = sec_q == 8'h59 ? inc60(min_q) : min_q;
                end
            end
            PAUSE: begin
                pre_d = pre_q;
                if (fs) begin
                    state_d = RUN;
                end else if (f2 || fl) begin
                    state_d = STOP;
                    min_d   = 8'h00;
                    sec_d   = 8'h00;
                end
            end
            SET: begin
                fast_d = (btn_long && !f4 && !fwrap) ? fast_q + 1'b1 : '0;
                if (f4) begin
                    state_d = STOP;
                end else if (f2) begin
                    field_d = ~field_q;
                end else if (fs || f3 || fwrap) begin
                    min_d = field_q ? nsel : min_q;
                    sec_d = field_q ? sec_q : nsel;
                end
            end
            DONE: begin
                min_d = 8'h00;
                sec_d = 8'h00;
                if (any_flag) state_d = STOP;
            end
            default: state_d = STOP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= STOP;
            min_q      <= 8'h00;
            sec_q      <= 8'h00;
            cd_q       <= 1'b0;
            field_q    <= 1'b0;
            pre_q      <= '0;
            fast_q     <= '0;
            running_q  <= 1'b0;
            set_mode_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            cd_q       <= cd_d;
            field_q    <= field_d;
            pre_q      <= pre_d;
            fast_q     <= fast_d;
            running_q  <= state_d == RUN;
            set_mode_q <= state_d == SET;
            alarm_q    <= state_d == DONE;
        end
    end

    assign {min_tens, min_ones} = min_q;
    assign {sec_tens, sec_ones} = sec_q;
    assign count_down = cd_q;
    assign running    = running_q;
    assign set_mode   = set_mode_q;
    assign set_field  = field_q;
    assign alarm      = alarm_q;
endmodule
